cp0_regfile: RTL

Coprocessor-0 register file: the receiving end of the write-back stage's CP0 bus. Each cycle it consumes the exception/eret/mtc0 fields committed by WB and updates BadVAddr, Count, Compare, Status, Cause and EPC. It returns mfc0 read data combinationally and drives the exception/eret redirect targets and the interrupt request to the front end.

---
 rtl/cp0_regfile_pkg.sv | 55 +++++
 rtl/cp0_timer.sv | 57 +++++
 rtl/cp0_regfile.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cp0_regfile_pkg
// Shared definitions for the CP0 register file and its producers:
//   - width and field layout of the write-back -> CP0 bus
//   - CP0 register numbers (sel 0 only)
//   - exception codes
//   - Status reset value and exception entry address
// -----------------------------------------------------------------------------
package cp0_regfile_pkg;

    localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

    // CP0 register numbers, sel 0.
    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } excode_e;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV = 1
    localparam logic [31:0] EX_ENTRY     = 32'hBFC0_0380;

    // Field layout of the bus, MSB first: {ex, excode, badvaddr, bd, pc,
    // mtc0_we, addr, wdata, eret} = bits [109] .. [0].
    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        bd;
        logic [31:0] pc;
        logic        mtc0_we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
    } wb_cp0_bus_t;

    // Address-error exceptions are the only ones that latch BadVAddr.
    function automatic logic is_addr_error(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer for CP0. Count advances once every two cycles; TI is
// raised (sticky) the cycle after Count == Compare and cleared by a Compare
// write.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   count_we     - committed mtc0 to Count (replaces the increment)
//   compare_we   - committed mtc0 to Compare (also clears TI)
//   wdata        - mtc0 write data
//   count        - current Count
//   compare      - current Compare
//   ti           - timer interrupt flag (Cause.TI)
// -----------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    // NOTE: reset is asynchronous; it is in the sensitivity list so state
    // clears without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q  <= 1'b0;
            count   <= 32'h0;
            compare <= 32'h0;
            ti      <= 1'b0;
        end else begin
            tick_q <= ~tick_q;

            // A Count write overrides the increment but leaves tick running.
            if (count_we)
                count <= wdata;
            else if (tick_q)
                count <= count + 32'd1;

            // A Compare write beats a simultaneous match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
// Coprocessor-0 register file fed by the write-back stage. Holds BadVAddr,
// Count, Compare, Status, Cause and EPC; serves mfc0 reads combinationally and
// drives eret/exception targets and the interrupt request.
// Build option: define CP0_TIMER_EN to implement Count/Compare/TI (cp0_timer).
// Without it Count and Compare read 0 and ignore writes, and TI is 0.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   ws_valid                - WB holds a valid instruction (qualifies ex/eret)
//   wb_to_cp0_register_bus  - committed CP0 fields from WB (see package)
//   ext_int                 - level-sensitive hardware interrupt lines
//   cp0_rdata               - CP0[addr] read data (combinational)
//   cp0_epc                 - EPC, the eret target
//   cp0_ex_entry            - exception entry address (constant)
//   cp0_int_req             - interrupt pending
// -----------------------------------------------------------------------------
module cp0_regfile
    import cp0_regfile_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ws_valid,
    input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
    input  logic [5:0]                           ext_int,
    output logic [31:0]                          cp0_rdata,
    output logic [31:0]                          cp0_epc,
    output logic [31:0]                          cp0_ex_entry,
    output logic                                 cp0_int_req
);

    wb_cp0_bus_t bus;
    assign bus = wb_to_cp0_register_bus;

    // Commit priority: exception > eret > mtc0.
    logic ex_commit, eret_commit, mtc0_commit;
    assign ex_commit   = ws_valid & bus.ex;
    assign eret_commit = ws_valid & bus.eret & ~bus.ex;
    assign mtc0_commit = bus.mtc0_we & ~ex_commit & ~eret_commit;

    logic wr_status, wr_cause, wr_epc;
    assign wr_status = mtc0_commit & (bus.addr == CP0_STATUS);
    assign wr_cause  = mtc0_commit & (bus.addr == CP0_CAUSE);
    assign wr_epc    = mtc0_commit & (bus.addr == CP0_EPC);

    // Architectural state
    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_hw_q;    // Cause.IP[7:2]
    logic [1:0]  ip_sw_q;    // Cause.IP[1:0]
    logic [4:0]  exccode_q;

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ti;

`ifdef CP0_TIMER_EN
    logic wr_count, wr_compare;
    assign wr_count   = mtc0_commit & (bus.addr == CP0_COUNT);
    assign wr_compare = mtc0_commit & (bus.addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (bus.wdata),
        .count      (count_q),
        .compare    (compare_q),
        .ti         (ti)
    );
`else
    assign count_q   = 32'h0;
    assign compare_q = 32'h0;
    assign ti        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q <= 32'h0;
            epc_q      <= 32'h0;
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'h0;
            ip_sw_q    <= 2'h0;
            exccode_q  <= 5'h0;
        end else begin
            // IP7 merges the timer; it is never software-writable.
            ip_hw_q <= {ext_int[5] | ti, ext_int[4:0]};

            if (ex_commit) begin
                // A nested exception (EXL already set) keeps the original EPC/BD.
                if (!exl_q) begin
                    epc_q <= bus.bd ? bus.pc - 32'd4 : bus.pc;
                    bd_q  <= bus.bd;
                end
                exl_q     <= 1'b1;
                exccode_q <= bus.excode;
                if (is_addr_error(bus.excode))
                    badvaddr_q <= bus.badvaddr;
            end else if (eret_commit) begin
                exl_q <= 1'b0;
            end else begin
                if (wr_status) begin
                    im_q  <= bus.wdata[15:8];
                    exl_q <= bus.wdata[1];
                    ie_q  <= bus.wdata[0];
                end
                if (wr_cause)
                    ip_sw_q <= bus.wdata[9:8];
                if (wr_epc)
                    epc_q <= bus.wdata;
            end
        end
    end

    logic [31:0] status_word, cause_word;
    assign status_word = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_word  = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

    // NOTE: always_comb assigns a default first so no path leaves cp0_rdata
    // unassigned, which would infer a latch.
    always_comb begin
        cp0_rdata = 32'h0;
        case (bus.addr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count_q;
            CP0_COMPARE:  cp0_rdata = compare_q;
            CP0_STATUS:   cp0_rdata = status_word;
            CP0_CAUSE:    cp0_rdata = cause_word;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = 32'h0;
        endcase
    end

    assign cp0_epc      = epc_q;
    assign cp0_ex_entry = EX_ENTRY;
    assign cp0_int_req  = ie_q & ~exl_q & |({ip_hw_q, ip_sw_q} & im_q);

endmodule
